// File: rtl/if_stage_if.sv
// IF-stage bundle: hazard/branch controls and imem word in, fetch address,
// IF/ID pipeline register and performance counters out.
interface if_stage_if #(
  parameter int CNT_W = 32
);
  logic             freeze;
  logic             branch_taken;
  logic [31:0]      branch_addr;
  logic [31:0]      instruction_in;
  logic [31:0]      PC_out;
  logic [31:0]      IF_ID_PC;
  logic [31:0]      IF_ID_instruction;
  logic             IF_ID_valid;
  logic [CNT_W-1:0] fetch_count;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output freeze, branch_taken, branch_addr, instruction_in,
    input  PC_out, IF_ID_PC, IF_ID_instruction, IF_ID_valid,
           fetch_count, stall_count
  );

  modport slave (
    input  freeze, branch_taken, branch_addr, instruction_in,
    output PC_out, IF_ID_PC, IF_ID_instruction, IF_ID_valid,
           fetch_count, stall_count
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC register, branch redirect, IF/ID register with
// freeze/flush, and saturating fetch/stall counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          CNT_W    = 32
) (
  input  logic       clk,
  input  logic       rst,
  if_stage_if.slave  bus
);
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic [31:0]      ifid_pc;
  logic [31:0]      ifid_instr;
  logic             ifid_vld;
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             advance;
  logic             stall;

  assign pc_plus4 = pc + 32'd4;
  assign advance  = !bus.branch_taken && !bus.freeze;
  // Branch beats freeze, so a cycle that redirects never counts as a stall.
  assign stall    = !bus.branch_taken && bus.freeze;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      ifid_pc    <= '0;
      ifid_instr <= '0;
      ifid_vld   <= 1'b0;
      fetch_cnt  <= '0;
      stall_cnt  <= '0;
    end else if (bus.branch_taken) begin
      pc         <= {bus.branch_addr[31:2], 2'b00};
      ifid_pc    <= '0;
      ifid_instr <= '0;
      ifid_vld   <= 1'b0;
    end else if (advance) begin
      pc         <= pc_plus4;
      ifid_pc    <= pc_plus4;
      ifid_instr <= bus.instruction_in;
      ifid_vld   <= 1'b1;
      if (fetch_cnt != '1) fetch_cnt <= fetch_cnt + 1'b1;
    end else if (stall) begin
      if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.PC_out            = pc;
  assign bus.IF_ID_PC          = ifid_pc;
  assign bus.IF_ID_instruction = ifid_instr;
  assign bus.IF_ID_valid       = ifid_vld;
  assign bus.fetch_count       = fetch_cnt;
  assign bus.stall_count       = stall_cnt;
endmodule
